// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive deserialiser: FSM state encoding, default
// oversampling ratios and the 3-sample majority voter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    localparam int OSR_A_DEF = 16;
    localparam int OSR_B_DEF = 13;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deser_if.sv
// Link between the receive FSM and the line sampler: run/ratio control in,
// synchronised line plus per-bit vote and timing strobes out.
interface uart_rx_deser_if;

    logic run;
    logic osr_sel;
    logic line;
    logic bit_val;
    logic bit_done;
    logic bit_end;

    modport master (
        output run,
        output osr_sel,
        input  line,
        input  bit_val,
        input  bit_done,
        input  bit_end
    );

    modport slave (
        input  run,
        input  osr_sel,
        output line,
        output bit_val,
        output bit_done,
        output bit_end
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, per-bit oversampling counter and majority voter.
// Vote is combinational off two stored samples plus the live line; no backpressure.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int OSR_A       = OSR_A_DEF,
    parameter int OSR_B       = OSR_B_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic         bclk_in,
    input  logic         rstn_in,
    input  logic         serial_in,
    uart_rx_deser_if.slave lnk
);

    localparam int OSR_MAX = (OSR_A > OSR_B) ? OSR_A : OSR_B;
    localparam int CNT_W   = $clog2(OSR_MAX);

    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(OSR_A - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(OSR_B - 1);
    localparam logic [CNT_W-1:0] MID_A  = CNT_W'((OSR_A - 1) / 2);
    localparam logic [CNT_W-1:0] MID_B  = CNT_W'((OSR_B - 1) / 2);
    localparam logic [CNT_W-1:0] LO_A   = CNT_W'((OSR_A - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] LO_B   = CNT_W'((OSR_B - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] HI_A   = CNT_W'((OSR_A - 1) / 2 + 1);
    localparam logic [CNT_W-1:0] HI_B   = CNT_W'((OSR_B - 1) / 2 + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   smp_lo_q;
    logic                   smp_mid_q;

    logic [CNT_W-1:0]       last_w;
    logic [CNT_W-1:0]       lo_w;
    logic [CNT_W-1:0]       mid_w;
    logic [CNT_W-1:0]       hi_w;

    assign last_w = lnk.osr_sel ? LAST_B : LAST_A;
    assign lo_w   = lnk.osr_sel ? LO_B   : LO_A;
    assign mid_w  = lnk.osr_sel ? MID_B  : MID_A;
    assign hi_w   = lnk.osr_sel ? HI_B   : HI_A;

    // Counter is held at zero while idle so the start edge always begins at cnt=0.
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync_q    <= '1;
            cnt_q     <= '0;
            smp_lo_q  <= 1'b1;
            smp_mid_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
            if (!lnk.run || cnt_q == last_w) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == lo_w) begin
                smp_lo_q <= lnk.line;
            end
            if (cnt_q == mid_w) begin
                smp_mid_q <= lnk.line;
            end
        end
    end

    assign lnk.line     = sync_q[SYNC_STAGES-1];
    assign lnk.bit_done = lnk.run && (cnt_q == hi_w);
    assign lnk.bit_end  = lnk.run && (cnt_q == last_w);
    assign lnk.bit_val  = maj3(smp_lo_q, smp_mid_q, lnk.line);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: frame FSM, LSB-first shifter, parity/framing/break flags.
// One-cycle valid_out strobe at the first stop bit's vote; no backpressure, frames are never held.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OSR_A       = OSR_A_DEF,
    parameter int OSR_B       = OSR_B_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         bclk_in,
    input  logic                         rstn_in,
    input  logic                         enable_in,
    input  logic                         serial_in,
    input  logic [$clog2(DATA_W+1)-1:0]  len_in,
    input  logic                         osm_sel_in,
    input  logic                         pen_in,
    input  logic                         eps_in,
    input  logic                         sp_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         valid_out,
    output logic                         pe_out,
    output logic                         fe_out,
    output logic                         bi_out,
    output logic                         busy_out
);

    localparam int LEN_W = $clog2(DATA_W + 1);

    uart_rx_deser_if lnk ();

    rx_state_e         state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              osr_sel_q;
    logic              pen_q;
    logic              eps_q;
    logic              sp_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] data_q;
    logic              zero_q;
    logic              par_err_q;
    logic              valid_q;
    logic              pe_q;
    logic              fe_q;
    logic              bi_q;
    logic              busy_q;

    logic              len_ok;
    logic              last_bit;
    logic              exp_par;
    logic              brk;

    uart_rx_sampler #(
        .OSR_A       (OSR_A),
        .OSR_B       (OSR_B),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .bclk_in   (bclk_in),
        .rstn_in   (rstn_in),
        .serial_in (serial_in),
        .lnk       (lnk)
    );

    assign lnk.run     = (state_q != ST_IDLE) && (state_q != ST_BRK_WAIT);
    assign lnk.osr_sel = osr_sel_q;

    assign len_ok   = (len_in >= LEN_W'(5)) && (len_in <= LEN_W'(DATA_W));
    assign last_bit = (idx_q == len_q - 1'b1);
    // Unreceived MSBs of the shifter stay 0, so the full-width XOR is the data XOR.
    assign exp_par  = sp_q ? ~eps_q : ((^shreg_q) ^ ~eps_q);
    assign brk      = zero_q & ~lnk.bit_val;

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            osr_sel_q <= 1'b0;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            shreg_q   <= '0;
            data_q    <= '0;
            zero_q    <= 1'b1;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable_in) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (len_ok && !lnk.line) begin
                            state_q   <= ST_START;
                            busy_q    <= 1'b1;
                            len_q     <= len_in;
                            osr_sel_q <= osm_sel_in;
                            pen_q     <= pen_in;
                            eps_q     <= eps_in;
                            sp_q      <= sp_in;
                            idx_q     <= '0;
                            shreg_q   <= '0;
                            zero_q    <= 1'b1;
                            par_err_q <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (lnk.bit_done && lnk.bit_val) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else if (lnk.bit_end) begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (lnk.bit_done) begin
                            shreg_q <= shreg_q | (DATA_W'(lnk.bit_val) << idx_q);
                            if (lnk.bit_val) begin
                                zero_q <= 1'b0;
                            end
                        end
                        if (lnk.bit_end) begin
                            if (last_bit) begin
                                state_q <= pen_q ? ST_PARITY : ST_STOP;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (lnk.bit_done) begin
                            par_err_q <= (lnk.bit_val != exp_par);
                            if (lnk.bit_val) begin
                                zero_q <= 1'b0;
                            end
                        end
                        if (lnk.bit_end) begin
                            state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Decide on the first stop bit's vote and leave immediately so
                        // a following start bit is caught without losing sync.
                        if (lnk.bit_done) begin
                            valid_q <= 1'b1;
                            pe_q    <= par_err_q;
                            fe_q    <= ~lnk.bit_val;
                            bi_q    <= brk;
                            data_q  <= brk ? '0 : shreg_q;
                            state_q <= brk ? ST_BRK_WAIT : ST_IDLE;
                            busy_q  <= brk;
                        end
                    end
                    ST_BRK_WAIT: begin
                        if (lnk.line) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign pe_out    = pe_q;
    assign fe_out    = fe_q;
    assign bi_out    = bi_q;
    assign busy_out  = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: tick-level serial waveforms against a frame-level model.
module tb_uart_rx_deser;

    localparam int DATA_W = 8;
    localparam int OSR_A  = 16;
    localparam int OSR_B  = 13;
    localparam int SYNC   = 2;

    logic       bclk   = 1'b0;
    logic       rstn   = 1'b0;
    logic       enable = 1'b0;
    logic       serial = 1'b1;
    logic [3:0] len    = 4'd8;
    logic       osm    = 1'b0;
    logic       pen    = 1'b0;
    logic       eps    = 1'b0;
    logic       sp     = 1'b0;

    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              pe_o;
    logic              fe_o;
    logic              bi_o;
    logic              busy_o;

    always #5 bclk = ~bclk;

    uart_rx_deser #(
        .DATA_W      (DATA_W),
        .OSR_A       (OSR_A),
        .OSR_B       (OSR_B),
        .SYNC_STAGES (SYNC)
    ) dut (
        .bclk_in    (bclk),
        .rstn_in    (rstn),
        .enable_in  (enable),
        .serial_in  (serial),
        .len_in     (len),
        .osm_sel_in (osm),
        .pen_in     (pen),
        .eps_in     (eps),
        .sp_in      (sp),
        .data_out   (data_o),
        .valid_out  (valid_o),
        .pe_out     (pe_o),
        .fe_out     (fe_o),
        .bi_out     (bi_o),
        .busy_out   (busy_o)
    );

    typedef struct packed {
        int         cyc;
        logic [7:0] dat;
        logic       pe;
        logic       fe;
        logic       bi;
    } strobe_t;

    typedef struct {
        logic [7:0] d;
        int         len;
        bit         pen;
        bit         eps;
        bit         sp;
        bit         osm;
        bit         par;
        bit         stop;
    } frame_t;

    int        cyc = 0;
    int        n_tests = 0;
    int        n_fail = 0;
    strobe_t   strobes[$];
    strobe_t   expq[$];
    frame_t    frames[$];
    logic      wave[$];
    int        start_idx[$];
    int        start_cyc[$];
    strobe_t   mon_s;
    logic      busy_before_drop;
    logic      busy_after_drop;
    logic [12:0] rst_snap;

    always @(posedge bclk) cyc <= cyc + 1;

    always @(negedge bclk) begin
        if (valid_o) begin
            mon_s.cyc = cyc;
            mon_s.dat = data_o;
            mon_s.pe  = pe_o;
            mon_s.fe  = fe_o;
            mon_s.bi  = bi_o;
            strobes.push_back(mon_s);
        end
    end

    function automatic int osr_of(input bit o);
        return o ? OSR_B : OSR_A;
    endfunction

    // Parity bit a correct transmitter would send for this frame.
    function automatic bit par_of(input frame_t f);
        int ones = 0;
        for (int k = 0; k < f.len; k++) ones += int'(f.d[k]);
        return f.sp ? !f.eps : (((ones % 2) == 1) ^ !f.eps);
    endfunction

    function automatic strobe_t model(input frame_t f, input int e0);
        strobe_t    r;
        int         osr;
        logic [7:0] dm;
        osr   = osr_of(f.osm);
        dm    = f.d & 8'((1 << f.len) - 1);
        r.bi  = (dm == 8'h00) && (!f.pen || !f.par) && !f.stop;
        r.cyc = e0 + osr * (1 + f.len + int'(f.pen)) + (osr - 1) / 2 + 2;
        r.dat = r.bi ? 8'h00 : dm;
        r.pe  = f.pen && (f.par != par_of(f));
        r.fe  = !f.stop;
        return r;
    endfunction

    function automatic frame_t mk(input logic [7:0] d, input int l, input bit p, input bit e,
                                  input bit s, input bit o, input bit flip, input bit stop);
        frame_t f;
        f.d = d; f.len = l; f.pen = p; f.eps = e; f.sp = s; f.osm = o; f.stop = stop;
        f.par = 1'b0;
        f.par = par_of(f) ^ flip;
        return f;
    endfunction

    task automatic clear();
        wave.delete(); start_idx.delete(); start_cyc.delete();
        frames.delete(); strobes.delete(); expq.delete();
    endtask

    task automatic set_cfg(input frame_t f);
        len = 4'(f.len); osm = f.osm; pen = f.pen; eps = f.eps; sp = f.sp;
    endtask

    task automatic add_level(input bit v, input int n);
        for (int k = 0; k < n; k++) wave.push_back(v);
    endtask

    task automatic add_frame(input frame_t f, input bit expect_it);
        int osr;
        osr = osr_of(f.osm);
        if (expect_it) begin
            start_idx.push_back(wave.size());
            frames.push_back(f);
        end
        add_level(1'b0, osr);
        for (int k = 0; k < f.len; k++) add_level(f.d[k], osr);
        if (f.pen) add_level(f.par, osr);
        add_level(f.stop, osr);
    endtask

    task automatic play(input int drop_tick, input int rst_tick);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge bclk);
            if (drop_tick >= 0 && i == drop_tick + 1) busy_after_drop = busy_o;
            if (i == drop_tick) begin
                busy_before_drop = busy_o;
                enable = 1'b0;
            end
            if (i == rst_tick) begin
                rstn = 1'b0;
                #1;
                rst_snap = {data_o, valid_o, pe_o, fe_o, bi_o, busy_o};
                serial = 1'b1;
                @(negedge bclk);
                rstn = 1'b1;
                break;
            end
            serial = wave[i];
            foreach (start_idx[k]) if (start_idx[k] == i) start_cyc.push_back(cyc);
        end
    endtask

    task automatic build_exp();
        expq.delete();
        for (int k = 0; k < frames.size() && k < start_cyc.size(); k++)
            expq.push_back(model(frames[k], start_cyc[k] + SYNC + 1));
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; serial = 1'b1;
        repeat (3) @(negedge bclk);
        n_tests++;
        if ({data_o, valid_o, pe_o, fe_o, bi_o, busy_o} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs %h, want 0", {data_o, valid_o, pe_o, fe_o, bi_o, busy_o});
        end
        rstn = 1'b1; enable = 1'b1;
        repeat (4) @(negedge bclk);
        n_tests++;
        if ({data_o, valid_o, pe_o, fe_o, bi_o, busy_o} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs %h, want 0", {data_o, valid_o, pe_o, fe_o, bi_o, busy_o});
        end
    endtask

    task automatic test_8n1();
        frame_t f;
        int     idx;
        clear();
        f = mk(8'hA5, 8, 0, 0, 0, 0, 0, 1);
        set_cfg(f);
        add_level(1'b1, 8); add_frame(f, 1); add_level(1'b1, 20);
        // Single-tick error on the centre sample of data bit 3.
        f = mk(8'h5A, 8, 0, 0, 0, 0, 0, 1);
        idx = wave.size();
        add_frame(f, 1); add_level(1'b1, 20);
        wave[idx + 4 * OSR_A + (OSR_A - 1) / 2 + 1] = !wave[idx + 4 * OSR_A + (OSR_A - 1) / 2 + 1];
        play(-1, -1);
        build_exp();
        n_tests++;
        if (strobes.size() != expq.size()) begin
            n_fail++;
            $display("FAIL 8n1_count: got %0d strobes, want %0d", strobes.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < strobes.size(); k++) begin
            n_tests++;
            if (strobes[k] !== expq[k]) begin
                n_fail++;
                $display("FAIL 8n1_frame%0d: got cyc=%0d dat=%h pe=%b fe=%b bi=%b, want cyc=%0d dat=%h pe=%b fe=%b bi=%b",
                         k, strobes[k].cyc, strobes[k].dat, strobes[k].pe, strobes[k].fe, strobes[k].bi,
                         expq[k].cyc, expq[k].dat, expq[k].pe, expq[k].fe, expq[k].bi);
            end
        end
    endtask

    task automatic test_parity();
        frame_t f;
        clear();
        f = mk(8'h3C, 7, 1, 1, 0, 1, 0, 1);
        set_cfg(f);
        add_level(1'b1, 8); add_frame(f, 1); add_level(1'b1, 20);
        f = mk(8'h3C, 7, 1, 1, 0, 1, 1, 1);
        add_frame(f, 1); add_level(1'b1, 20);
        play(-1, -1);
        build_exp();
        n_tests++;
        if (strobes.size() != expq.size()) begin
            n_fail++;
            $display("FAIL parity_count: got %0d strobes, want %0d", strobes.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < strobes.size(); k++) begin
            n_tests++;
            if (strobes[k] !== expq[k]) begin
                n_fail++;
                $display("FAIL parity_frame%0d: got cyc=%0d dat=%h pe=%b fe=%b bi=%b, want cyc=%0d dat=%h pe=%b fe=%b bi=%b",
                         k, strobes[k].cyc, strobes[k].dat, strobes[k].pe, strobes[k].fe, strobes[k].bi,
                         expq[k].cyc, expq[k].dat, expq[k].pe, expq[k].fe, expq[k].bi);
            end
        end
    endtask

    task automatic test_stick();
        frame_t f;
        clear();
        // Stick parity with eps=0 expects a 1; send 0 to force a parity error.
        f = mk(8'h15, 5, 1, 0, 1, 0, 0, 1);
        f.par = 1'b0;
        set_cfg(f);
        add_level(1'b1, 8); add_frame(f, 1); add_level(1'b1, 24);
        f.stop = 1'b0;
        add_frame(f, 1); add_level(1'b1, 40);
        play(-1, -1);
        build_exp();
        n_tests++;
        if (strobes.size() != expq.size()) begin
            n_fail++;
            $display("FAIL stick_count: got %0d strobes, want %0d", strobes.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < strobes.size(); k++) begin
            n_tests++;
            if (strobes[k] !== expq[k]) begin
                n_fail++;
                $display("FAIL stick_frame%0d: got cyc=%0d dat=%h pe=%b fe=%b bi=%b, want cyc=%0d dat=%h pe=%b fe=%b bi=%b",
                         k, strobes[k].cyc, strobes[k].dat, strobes[k].pe, strobes[k].fe, strobes[k].bi,
                         expq[k].cyc, expq[k].dat, expq[k].pe, expq[k].fe, expq[k].bi);
            end
        end
    endtask

    task automatic test_break();
        frame_t f;
        clear();
        f = mk(8'h00, 8, 0, 0, 0, 0, 0, 0);
        set_cfg(f);
        add_level(1'b1, 8);
        start_idx.push_back(wave.size());
        frames.push_back(f);
        add_level(1'b0, 20 * OSR_A);
        play(-1, -1);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL break_busy_low: busy_out=%b, want 1", busy_o);
        end
        wave.delete(); start_idx.delete();
        add_level(1'b1, 40);
        play(-1, -1);
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL break_busy_high: busy_out=%b, want 0", busy_o);
        end
        build_exp();
        n_tests++;
        if (strobes.size() != expq.size()) begin
            n_fail++;
            $display("FAIL break_count: got %0d strobes, want %0d", strobes.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < strobes.size(); k++) begin
            n_tests++;
            if (strobes[k] !== expq[k]) begin
                n_fail++;
                $display("FAIL break_frame%0d: got cyc=%0d dat=%h pe=%b fe=%b bi=%b, want cyc=%0d dat=%h pe=%b fe=%b bi=%b",
                         k, strobes[k].cyc, strobes[k].dat, strobes[k].pe, strobes[k].fe, strobes[k].bi,
                         expq[k].cyc, expq[k].dat, expq[k].pe, expq[k].fe, expq[k].bi);
            end
        end
    endtask

    task automatic test_glitch();
        clear();
        len = 4'd8; osm = 1'b0; pen = 1'b0;
        add_level(1'b1, 8); add_level(1'b0, 4); add_level(1'b1, 3);
        play(-1, -1);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_start_seen: busy_out=%b, want 1", busy_o);
        end
        wave.delete();
        add_level(1'b1, 40);
        play(-1, -1);
        n_tests++;
        if (strobes.size() != 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: strobes=%0d busy_out=%b, want 0 and 0", strobes.size(), busy_o);
        end
    endtask

    task automatic test_enable_drop();
        frame_t f;
        clear();
        f = mk(8'hFF, 8, 0, 0, 0, 0, 0, 1);
        set_cfg(f);
        add_level(1'b1, 8); add_frame(f, 0); add_level(1'b1, 40);
        play(8 + 3 * OSR_A + 5, -1);
        n_tests++;
        if (busy_before_drop !== 1'b1 || busy_after_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_busy: before=%b after=%b, want 1 then 0", busy_before_drop, busy_after_drop);
        end
        enable = 1'b1;
        wave.delete();
        add_level(1'b1, 30);
        play(-1, -1);
        n_tests++;
        if (strobes.size() != 0) begin
            n_fail++;
            $display("FAIL enable_drop_strobe: got %0d strobes, want 0", strobes.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t f;
        int     b0;
        clear();
        f = mk(8'hC3, 8, 0, 0, 0, 0, 0, 1);
        set_cfg(f);
        add_level(1'b1, 8); add_frame(f, 1); add_level(1'b1, 16);
        b0 = wave.size();
        add_frame(mk(8'h7E, 8, 0, 0, 0, 0, 0, 1), 0);
        play(-1, b0 + 4 * OSR_A + 3);
        n_tests++;
        if (rst_snap !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: outputs %h, want 0", rst_snap);
        end
        wave.delete(); start_idx.delete();
        add_level(1'b1, 8); add_frame(mk(8'h96, 8, 0, 0, 0, 0, 0, 1), 1); add_level(1'b1, 20);
        play(-1, -1);
        build_exp();
        n_tests++;
        if (strobes.size() != expq.size()) begin
            n_fail++;
            $display("FAIL reset_count: got %0d strobes, want %0d", strobes.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < strobes.size(); k++) begin
            n_tests++;
            if (strobes[k] !== expq[k]) begin
                n_fail++;
                $display("FAIL reset_frame%0d: got cyc=%0d dat=%h pe=%b fe=%b bi=%b, want cyc=%0d dat=%h pe=%b fe=%b bi=%b",
                         k, strobes[k].cyc, strobes[k].dat, strobes[k].pe, strobes[k].fe, strobes[k].bi,
                         expq[k].cyc, expq[k].dat, expq[k].pe, expq[k].fe, expq[k].bi);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f1;
        frame_t f2;
        clear();
        for (int p = 0; p < 4; p++) begin
            wave.delete(); start_idx.delete();
            f1 = mk(8'($urandom), int'($urandom_range(5, 8)), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'b1);
            f2 = mk(8'($urandom), f1.len, f1.pen, f1.eps, f1.sp, f1.osm, 1'($urandom),
                    $urandom_range(0, 3) != 0);
            set_cfg(f1);
            add_level(1'b1, 8); add_frame(f1, 1); add_frame(f2, 1);
            add_level(1'b1, 2 * osr_of(f1.osm) + 4);
            play(-1, -1);
        end
        build_exp();
        n_tests++;
        if (strobes.size() != expq.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d strobes, want %0d", strobes.size(), expq.size());
        end
        for (int k = 0; k < expq.size() && k < strobes.size(); k++) begin
            n_tests++;
            if (strobes[k] !== expq[k]) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got cyc=%0d dat=%h pe=%b fe=%b bi=%b, want cyc=%0d dat=%h pe=%b fe=%b bi=%b",
                         k, strobes[k].cyc, strobes[k].dat, strobes[k].pe, strobes[k].fe, strobes[k].bi,
                         expq[k].cyc, expq[k].dat, expq[k].pe, expq[k].fe, expq[k].bi);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stick();
        test_break();
        test_glitch();
        test_enable_drop();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Parametrised UART receive deserialiser: the next-generation receive shifter with configurable maximum data width, configurable oversampling ratios, 3-sample majority voting, parity checking and break detection. Sits between the RX pin and the receive FIFO. Samples on the oversampling clock and emits one parallel character plus error flags per frame.

## Interface
- DATA_W, 8, maximum data bits per character (≥5)
- OSR_A, 16, oversampling ratio when osm_sel_in=0
- OSR_B, 13, oversampling ratio when osm_sel_in=1
- SYNC_STAGES, 2, serial_in synchroniser depth (≥2)
- bclk_in  in  1  oversampling clock, every edge is one sample tick
- rstn_in  in  1  reset; one clock domain (bclk_in); asynchronous, active-low
- enable_in  in  1  receiver enable
- serial_in  in  1  asynchronous RX line, idle high
- len_in  in  $clog2(DATA_W+1)  data bits per char, legal 5..DATA_W
- osm_sel_in  in  1  selects OSR_B
- pen_in / eps_in / sp_in  in  1  parity enable / even parity / stick parity
- data_out  out  DATA_W  received char, LSB first, unused MSBs 0
- valid_out  out  1  one-cycle strobe, data_out and flags valid
- pe_out / fe_out / bi_out  out  1  parity error / framing error / break, qualified by valid_out
- busy_out  out  1  high in any state except IDLE

## Operation
- serial_in passes SYNC_STAGES flops, reset to 1; "line" below means the synchronised value.
- Config (len_in, osm_sel_in, pen_in, eps_in, sp_in) is latched on start detect and held for the frame.
- OSR = OSR_A or OSR_B; MID = (OSR-1)/2 (16→7, 13→6). Bit counter cnt runs 0..OSR-1 and wraps.
- Bit value = majority of line at cnt MID-1, MID, MID+1; decided on the edge ending cnt=MID+1.
- States:
  - IDLE: when enable_in=1, len legal and line=0 → START, cnt=0.
  - START: voted 1 (glitch) → IDLE with no strobe. Otherwise at cnt wrap → DATA.
  - DATA: shift voted bits LSB first into data_out[0..len-1]. After bit len-1 wraps → PARITY if pen, else STOP.
  - PARITY:
    - expected bit: sp=1 → !eps; sp=0 → XOR(data) ^ !eps (eps=1 even).
    - pe = voted ≠ expected. At wrap → STOP.
  - STOP: only the first stop bit is sampled; fe = voted 0. On the deciding edge, valid_out=1 and flags are registered.
    - bi = all data, parity and stop bits 0. In that case data_out=0, and the next state is BRK_WAIT; otherwise IDLE.
    - No wait for the end of the stop bit, so back-to-back frames resync.
  - BRK_WAIT: hold until line=1 → IDLE.
- enable_in=0 in any state → IDLE next edge, no strobe, partial data discarded.
- len_in illegal (<5 or >DATA_W) in IDLE → remain IDLE.

## Timing
- Reset values: data_out=0, valid_out=0, pe/fe/bi=0, busy_out=0, state IDLE, synchroniser flops =1.
- E0 = edge at which IDLE first sees line=0.
- valid_out rises at edge E0 + OSR·(1+len+pen) + MID + 2 and falls one edge later.
  - Example: OSR 16, 8N1 → E0+153.
- Pin-to-line latency: SYNC_STAGES edges.
- data_out and flags hold their value until the next valid_out strobe. busy_out drops on the same edge valid_out rises (unless going to BRK_WAIT).
- A new start can be detected on the edge after valid_out rises.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous).

## Structure
- Package uart_rx_pkg: state enumeration (IDLE, START, DATA, PARITY, STOP, BRK_WAIT) and default OSR constants.
- Sub-module uart_rx_sampler contains the synchroniser, cnt, and the 3-sample majority voter. It outputs bit_val, bit_done (the MID+1 decision strobe) and bit_end (the wrap strobe).
- The top level holds the FSM, shift register, parity and flags.

## Test plan
- OSR 16, 8N1, send 0xA5 → valid_out at E0+153, data_out=0xA5, pe=fe=bi=0.
- OSR 13 (osm_sel_in=1), 7E1, send 0x3C with a correct parity bit → data_out=0x3C, pe=0. Repeat with the parity bit flipped → pe=1.
- 5-bit, stick parity sp=1/eps=0, send 0x15 with parity=0 → pe=1. Repeat with stop bit 0 → fe=1.
- Line held low for 20 bit times → one strobe with bi=1, fe=1, data_out=0. busy_out stays 1 until line=1, then no further strobe.
- 4-tick low glitch → no strobe, return to IDLE. Single-tick error at cnt=MID inside a data bit → bit still received correctly.
- enable_in dropped mid-DATA → no strobe, busy_out=0 next edge. rstn_in pulsed mid-frame → all outputs 0 immediately, and the next clean frame is received correctly.
